muldiv_unit: RTL and testbench

Iterative 32-bit multiply/divide unit for the RV32 pipeline. It implements the M-extension operations MUL, DIV, DIVU, REM and REMU with a start/busy/valid handshake. The single-cycle ALU issues these requests to the unit, and the hazard logic stalls EX while `busy_o` is high. Each multiply or normal divide takes one iteration per bit. The result is written back by EX when `valid_o` pulses.

---
 rtl/muldiv_unit_pkg.sv | 16 +
 rtl/muldiv_unit.sv | 149 ++++++++++++++
 tb/tb_muldiv_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared M-extension definitions for the RV32 multiply/divide unit.
// Opcodes match the instruction funct3 field.
package muldiv_unit_pkg;

  localparam int XLEN = 32;
  localparam int CNTW = $clog2(XLEN);

  localparam logic [2:0] MD_MUL  = 3'b000;
  localparam logic [2:0] MD_DIV  = 3'b100;
  localparam logic [2:0] MD_DIVU = 3'b101;
  localparam logic [2:0] MD_REM  = 3'b110;
  localparam logic [2:0] MD_REMU = 3'b111;

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

endpackage

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider with a
// start/busy/valid handshake; one iteration per operand bit.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] data1_i,
  input  logic [XLEN-1:0] data2_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] data_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [2*XLEN-1:0] acc_q, acc_nx;
  logic [XLEN-1:0]   quo_q, quo_nx;
  logic [XLEN-1:0]   opnd_q, res_q;
  logic [CNTW-1:0]   cnt_q;
  logic              mul_q, rem_q;
  logic              negq_q, negr_q;

  logic            accept, last;
  logic            is_div, sgn, div0, ovf;
  logic            special, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag, spc_res;
  logic [XLEN-1:0] mcand, sub;
  logic [XLEN:0]   sum;
  logic            ge;
  logic [XLEN-1:0] q_fin, r_fin, fin_res;

  assign accept  = start_i && (state_q != S_BUSY);
  assign last    = cnt_q == CNTW'(XLEN-1);
  assign is_div  = op_i[2];
  assign sgn     = is_div && !op_i[0];
  assign div0    = is_div && (data2_i == '0);
  assign ovf     = sgn && (data1_i == MIN_INT)
                   && (data2_i == '1);
  assign special = (op_i != MD_MUL)
                   && (!is_div || div0 || ovf);

  assign a_neg = sgn && data1_i[XLEN-1];
  assign b_neg = sgn && data2_i[XLEN-1];
  assign a_mag = a_neg ? -data1_i : data1_i;
  assign b_mag = b_neg ? -data2_i : data2_i;

  // op_i[1] selects the remainder flavour of a divide
  always_comb begin
    spc_res = '0;
    unique case (1'b1)
      div0:    spc_res = op_i[1] ? data1_i : '1;
      ovf:     spc_res = op_i[1] ? '0 : MIN_INT;
      default: spc_res = '0;
    endcase
  end

  always_comb begin
    mcand = quo_q[0] ? opnd_q : '0;
    sum   = {1'b0, acc_q[2*XLEN-1:XLEN]}
            + {1'b0, mcand};
    // 33-bit partial remainder vs divisor
    ge    = acc_q[2*XLEN-1:XLEN-1]
            >= {1'b0, opnd_q};
    sub   = acc_q[2*XLEN-2:XLEN-1] - opnd_q;
    if (mul_q) begin
      acc_nx = {sum, acc_q[XLEN-1:1]};
      quo_nx = {1'b0, quo_q[XLEN-1:1]};
    end else begin
      acc_nx = ge
        ? {sub, acc_q[XLEN-2:0], 1'b0}
        : {acc_q[2*XLEN-2:0], 1'b0};
      quo_nx = {quo_q[XLEN-2:0], ge};
    end
    q_fin = negq_q ? -quo_nx : quo_nx;
    r_fin = negr_q ? -acc_nx[2*XLEN-1:XLEN]
                   : acc_nx[2*XLEN-1:XLEN];
    if (mul_q)
      fin_res = acc_nx[XLEN-1:0];
    else
      fin_res = rem_q ? r_fin : q_fin;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept)
          state_d = special ? S_DONE : S_BUSY;
        else
          state_d = S_IDLE;
      end
      S_BUSY: if (last) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      quo_q   <= '0;
      opnd_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      mul_q   <= 1'b0;
      rem_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q  <= '0;
        mul_q  <= op_i == MD_MUL;
        rem_q  <= op_i[1];
        negq_q <= a_neg ^ b_neg;
        negr_q <= a_neg;
        if (op_i == MD_MUL) begin
          acc_q  <= '0;
          quo_q  <= data2_i;
          opnd_q <= data1_i;
        end else begin
          acc_q  <= {{XLEN{1'b0}}, a_mag};
          quo_q  <= '0;
          opnd_q <= b_mag;
        end
        if (special) res_q <= spc_res;
      end else if (state_q == S_BUSY) begin
        acc_q <= acc_nx;
        quo_q <= quo_nx;
        cnt_q <= cnt_q + CNTW'(1);
        if (last) res_q <= fin_res;
      end
    end
  end

  assign busy_o  = state_q == S_BUSY;
  assign valid_o = state_q == S_DONE;
  assign data_o  = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors, expected
// result, valid cycle and busy length queued at issue.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  op;
  logic [31:0] d1, d2;
  logic        busy, valid;
  logic [31:0] data;

  muldiv_unit dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .op_i    (op),
    .data1_i (d1),
    .data2_i (d2),
    .busy_o  (busy),
    .valid_o (valid),
    .data_o  (data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    int          busy;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_valid = 0;
  int   busy_run = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; start is sampled at the next posedge.
  task automatic issue(input logic [2:0] o,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] e,
                       input int lat);
    start = 1'b1;
    op    = o;
    d1    = a;
    d2    = b;
    sb.push_back('{data: e, cyc: cyc + lat,
                   busy: (lat > 1) ? 32 : 0});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("drain_outstanding", sb.size(), 0);
    sb.delete();
  endtask

  task automatic run(input logic [2:0] o,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [31:0] e,
                     input int lat);
    @(negedge clk);
    issue(o, a, b, e, lat);
    drain();
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        busy_run = 0;
      end else begin
        if (busy === 1'b1) busy_run++;
        if (valid === 1'b1) begin
          n_valid++;
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_valid: got data %h, expected no valid",
                     data);
          end else begin
            e = sb.pop_front();
            chk("data", data, e.data);
            chk("valid_cycle", cyc, e.cyc);
            chk("busy_cycles", busy_run, e.busy);
          end
          busy_run = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    int v0;
    rst   = 1'b1;
    start = 1'b0;
    op    = 3'b000;
    d1    = '0;
    d2    = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_valid", valid, 0);
    chk("reset_data", data, 0);
    rst = 1'b0;

    run(MD_MUL,  32'd7, 32'd6, 32'd42, 33);
    run(MD_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    run(MD_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    run(MD_DIVU, 32'd100, 32'd7, 32'd14, 33);
    run(MD_REMU, 32'd100, 32'd7, 32'd2, 33);
    run(MD_DIV,  32'd5, 32'd0, 32'hFFFFFFFF, 1);
    run(MD_REM,  32'd5, 32'd0, 32'd5, 1);
    run(MD_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run(MD_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
    run(3'b011,  32'd9, 32'd4, 32'd0, 1);
    run(MD_DIVU, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 1);
    run(MD_DIVU, 32'hFFFFFFFF, 32'd10, 32'h19999999, 33);
    run(MD_REMU, 32'hFFFFFFFF, 32'd10, 32'd5, 33);
    run(MD_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 33);
    run(MD_DIV,  32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 33);
    run(MD_DIV,  32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 33);
    run(MD_REM,  32'd100, 32'hFFFFFFF9, 32'd2, 33);

    // starts and operand changes while busy must be ignored
    v0 = n_valid;
    @(negedge clk);
    issue(MD_MUL, 32'd1234, 32'd5678, 32'd7006652, 33);
    for (int i = 0; i < 10; i++) begin
      start = i[0];
      op    = MD_DIVU;
      d1    = $urandom;
      d2    = $urandom;
      @(negedge clk);
    end
    start = 1'b0;
    drain();
    repeat (40) @(negedge clk);
    chk("ignore_valid_pulses", n_valid - v0, 1);

    // reset in the middle of a divide
    @(negedge clk);
    issue(MD_DIV, 32'd1000, 32'd7, 32'd142, 33);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    chk("abort_busy", busy, 0);
    chk("abort_valid", valid, 0);
    chk("abort_data", data, 0);
    run(MD_DIVU, 32'd9, 32'd3, 32'd3, 33);

    // new start issued in the DONE cycle
    @(negedge clk);
    issue(MD_MUL, 32'd3, 32'd5, 32'd15, 33);
    k = 0;
    while (valid !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("b2b_done_seen", valid, 1);
    issue(MD_DIVU, 32'd1000, 32'd7, 32'd142, 33);
    repeat (30) @(negedge clk);
    chk("b2b_hold_data", data, 32'd15);
    chk("b2b_busy", busy, 1);
    drain();

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
